ps2_tx: RTL

PS2_TX -- requirements
Module: ps2_tx

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_clk_filter.sv | 37 +++
 rtl/ps2_tx.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, debug view and
// the keyboard command/response bytes used by the controller.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RTS   = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } ps2_state_e;

  typedef struct packed {
    ps2_state_e state;
    logic       clk_filt;
  } ps2_dbg_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Debounces the sensed PS/2 clock with an 8-sample window and flags its
// falling edges; shared by the host transmitter and receiver.
module ps2_clk_filter (
  input  logic clk,
  input  logic reset,
  input  logic ps2c_in,
  output logic filt,
  output logic neg_edge
);

  logic [7:0] sr_q, sr_d;
  logic       filt_q, filt_d;

  always_comb begin
    sr_d   = {ps2c_in, sr_q[7:1]};
    filt_d = filt_q;
    if (sr_q == 8'hFF)
      filt_d = 1'b1;
    else if (sr_q == 8'h00)
      filt_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q   <= 8'h00;
      filt_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      filt_q <= filt_d;
    end
  end

  // Both terms come from flops, so the edge flag has no path from ps2c_in.
  assign filt     = filt_q;
  assign neg_edge = filt_q & ~filt_d;

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device byte transmitter: inhibits the clock, issues the start
// bit, shifts d0..d7 and odd parity on device clock falls, then checks ACK.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       ack_err,
  output ps2_dbg_t   dbg
);

  localparam int CW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  // Handshake: a request is accepted only in the cycle wr_ps2=1 while
  // tx_idle=1; tx_done_tick pulses once per accepted request, never otherwise.
  ps2_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [8:0]  shift_q, shift_d;
  logic [3:0]  n_q, n_d;
  logic        ack_err_q, ack_err_d;
  logic        done_q, done_d;
  logic        c_oe_q, c_oe_d;
  logic        d_oe_q, d_oe_d;
  logic        idle_q, idle_d;
  logic        clk_filt;
  logic        neg_edge;

  ps2_clk_filter u_filt (
    .clk      (clk),
    .reset    (reset),
    .ps2c_in  (ps2c_in),
    .filt     (clk_filt),
    .neg_edge (neg_edge)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wd_d      = wd_q;
    shift_d   = shift_q;
    n_d       = n_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (wr_ps2) begin
          shift_d   = {odd_parity(din), din};
          cnt_d     = CW'(INHIBIT_CYCLES - 1);
          ack_err_d = 1'b0;
          state_d   = ST_RTS;
        end
      end
      ST_RTS: begin
        if (cnt_q == '0) begin
          state_d = ST_START;
          wd_d    = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_START: begin
        if (neg_edge) begin
          state_d = ST_DATA;
          n_d     = 4'd8;
        end
      end
      ST_DATA: begin
        if (neg_edge) begin
          if (n_q == 4'd0) begin
            state_d = ST_STOP;
          end else begin
            shift_d = shift_q >> 1;
            n_d     = n_q - 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (neg_edge) begin
          ack_err_d = ps2d_in;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Watchdog restarts on every device clock fall; a silent device aborts.
    if (state_q == ST_START || state_q == ST_DATA || state_q == ST_STOP) begin
      if (neg_edge) begin
        wd_d = '0;
      end else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
        state_d   = ST_IDLE;
        ack_err_d = 1'b1;
        done_d    = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end

    c_oe_d = (state_d == ST_RTS);
    d_oe_d = (state_d == ST_START) || (state_d == ST_DATA && !shift_d[0]);
    idle_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wd_q      <= '0;
      shift_q   <= '0;
      n_q       <= '0;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
      c_oe_q    <= 1'b0;
      d_oe_q    <= 1'b0;
      idle_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wd_q      <= wd_d;
      shift_q   <= shift_d;
      n_q       <= n_d;
      ack_err_q <= ack_err_d;
      done_q    <= done_d;
      c_oe_q    <= c_oe_d;
      d_oe_q    <= d_oe_d;
      idle_q    <= idle_d;
    end
  end

  assign ps2c_oe      = c_oe_q;
  assign ps2d_oe      = d_oe_q;
  assign tx_idle      = idle_q;
  assign tx_done_tick = done_q;
  assign ack_err      = ack_err_q;
  assign dbg          = '{state: state_q, clk_filt: clk_filt};

endmodule
